// File: rtl/demux_serial_feeder.sv
// Serialises a parallel word MSB-first onto demux input `a`, holding the channel on the selects.
// Optional even-parity bit after the LSB when DEMUX_FEEDER_PARITY_EN is defined.
module demux_serial_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_ch,
  output logic             a,
  output logic             s0,
  output logic             s1,
  output logic             bit_active,
  output logic             done
);

`ifdef DEMUX_FEEDER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [FRAME-1:0]   sreg, sreg_d, frame_c;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [1:0]         sel, sel_d;
  logic               a_d, bit_active_d, done_d, in_ready_d;
  logic               last_bit_c, gap_end_c;

`ifdef DEMUX_FEEDER_PARITY_EN
  assign frame_c = {in_data, ^in_data};
`else
  assign frame_c = in_data;
`endif

  // bit_cnt counts bits already driven onto `a`; the frame is complete once it reaches FRAME
  assign last_bit_c = (bit_cnt == CNT_W'(FRAME));
  assign gap_end_c  = (gap_cnt == GAP_W'(GAP_CYCLES));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sel        <= 2'b00;
      a          <= 1'b0;
      bit_active <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      sel        <= sel_d;
      a          <= a_d;
      bit_active <= bit_active_d;
      done       <= done_d;
      in_ready   <= in_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit_c) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_end_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for datapath and output registers; the MSB leaves on the accepting edge
  always_comb begin
    sreg_d       = sreg;
    bit_cnt_d    = bit_cnt;
    gap_cnt_d    = gap_cnt;
    sel_d        = sel;
    a_d          = 1'b0;
    bit_active_d = 1'b0;
    done_d       = 1'b0;
    in_ready_d   = (state_d == ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          a_d          = frame_c[FRAME-1];
          sreg_d       = {frame_c[FRAME-2:0], 1'b0};
          bit_active_d = 1'b1;
          bit_cnt_d    = CNT_W'(1);
          sel_d        = in_ch;
        end
      end
      ST_SHIFT: begin
        if (last_bit_c) begin
          bit_cnt_d = '0;
          gap_cnt_d = GAP_W'(1);
        end else begin
          a_d          = sreg[FRAME-1];
          sreg_d       = {sreg[FRAME-2:0], 1'b0};
          bit_active_d = 1'b1;
          bit_cnt_d    = bit_cnt + CNT_W'(1);
          done_d       = (bit_cnt_d == CNT_W'(FRAME));
        end
      end
      ST_GAP: begin
        if (gap_end_c) gap_cnt_d = '0;
        else           gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: begin
        bit_cnt_d = '0;
        gap_cnt_d = '0;
      end
    endcase
  end

  assign s0 = sel[0];
  assign s1 = sel[1];

endmodule

// File: tb/tb_demux_serial_feeder.sv
// Bench for demux_serial_feeder: frame-queue reference model plus directed literal checks.
module tb_demux_serial_feeder;

  localparam int unsigned W = 8;
`ifdef DEMUX_FEEDER_PARITY_EN
  localparam int unsigned GAP = 0;
  localparam int unsigned FR  = W + 1;
  localparam logic [7:0] D1  = 8'h07;
  localparam logic [1:0] C1  = 2'd1;
  localparam logic [8:0] E1  = 9'h00F;
  localparam logic [8:0] E3C = 9'h078;
  localparam logic [8:0] EF0 = 9'h1E0;
  localparam logic [8:0] E55 = 9'h0AA;
`else
  localparam int unsigned GAP = 1;
  localparam int unsigned FR  = W;
  localparam logic [7:0] D1  = 8'hA5;
  localparam logic [1:0] C1  = 2'd2;
  localparam logic [8:0] E1  = 9'h0A5;
  localparam logic [8:0] E3C = 9'h03C;
  localparam logic [8:0] EF0 = 9'h0F0;
  localparam logic [8:0] E55 = 9'h055;
`endif
  localparam int unsigned P = FR + GAP + 1;

  typedef struct packed {
    logic in_ready;
    logic s1;
    logic s0;
    logic a;
    logic bit_active;
    logic done;
  } smp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_ch;
  logic         a, s0, s1, bit_active, done;
  logic [5:0]   outs;
  bit           chk_en = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  smp_t cur;
  smp_t q[$];

  assign outs = {in_ready, s1, s0, a, bit_active, done};

  always #5 clk = ~clk;

  demux_serial_feeder #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .a(a), .s0(s0), .s1(s1),
    .bit_active(bit_active), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FR-1:0] frame_of(input logic [7:0] d);
`ifdef DEMUX_FEEDER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Reference: an accepted word expands into a list of per-cycle samples (frame bits, then gap)
  always @(posedge clk) begin : model
    smp_t nxt;
    logic [FR-1:0] fr;
    if (rst) begin
      q.delete();
      nxt = 6'b100000;
    end else begin
      if (cur.in_ready && in_valid) begin
        fr = frame_of(in_data);
        for (int i = int'(FR) - 1; i >= 0; i--)
          q.push_back('{in_ready: 1'b0, s1: in_ch[1], s0: in_ch[0], a: fr[i],
                        bit_active: 1'b1, done: (i == 0)});
        for (int g = 0; g < int'(GAP); g++)
          q.push_back('{in_ready: 1'b0, s1: in_ch[1], s0: in_ch[0], a: 1'b0,
                        bit_active: 1'b0, done: 1'b0});
      end
      if (q.size() > 0) nxt = q.pop_front();
      else nxt = '{in_ready: 1'b1, s1: cur.s1, s0: cur.s0, a: 1'b0, bit_active: 1'b0, done: 1'b0};
    end
    cur <= nxt;
  end

  always @(negedge clk) begin
    if (chk_en) check("model", 32'(outs), 32'(cur));
  end

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(in_ready), 32'd1);
  endtask

  // Starts at an idle negedge; optionally drives a competing word in cycle junk_at
  task automatic run_frame(input logic [7:0] d, input logic [1:0] ch,
                           input logic [8:0] exp_bits, input int junk_at);
    logic [8:0] bits = '0;
    logic [8:0] dv = '0;
    int selbad = 0;
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = ch;
    for (int c = 1; c <= int'(FR); c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c == junk_at) begin
        in_valid = 1'b1;
        in_data  = 8'h0F;
        in_ch    = 2'd3;
      end
      bits = {bits[7:0], a};
      dv   = {dv[7:0], done};
      if (bit_active !== 1'b1 || {s1, s0} !== ch) selbad++;
    end
    check("frame_bits", 32'(bits), 32'(exp_bits));
    check("done_pos", 32'(dv), 32'h001);
    check("sel_active", 32'(selbad), 32'd0);
    for (int g = 0; g < int'(GAP); g++) begin
      @(negedge clk);
      check("gap", 32'({in_ready, a, bit_active, done, s1, s0}), 32'({4'b0000, ch}));
    end
    @(negedge clk);
    check("ready_after", 32'(in_ready), 32'd1);
    if (junk_at > 0) begin
      @(negedge clk);
      check("junk_accepted", 32'({in_ready, s1, s0, bit_active}), 32'(4'b0111));
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int dcnt;
    logic [8:0] bits2;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_ch    = 2'd0;
    repeat (3) begin
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_hold", 32'(outs), 32'(6'b100000));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(outs), 32'(6'b100000));

    run_frame(D1, C1, E1, 0);

    // back-to-back with in_valid held high
    dcnt  = 0;
    bits2 = '0;
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_ch    = 2'd0;
    for (int c = 1; c <= int'(P + FR); c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_data = 8'h3C;
        in_ch   = 2'd3;
      end
      if (done === 1'b1) dcnt++;
      if (c == int'(P)) check("b2b_ready", 32'(in_ready), 32'd1);
      if (c == int'(P) + 1) check("b2b_sel", 32'({s1, s0}), 32'd3);
      if (c > int'(P)) bits2 = {bits2[7:0], a};
    end
    in_valid = 1'b0;
    check("b2b_done", 32'(dcnt), 32'd2);
    check("b2b_bits", 32'(bits2), 32'(E3C));
    wait_idle();

    run_frame(8'hF0, 2'd1, EF0, 3);
    wait_idle();

    // reset in the middle of a frame
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_ch    = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    check("mid_reset", 32'(outs), 32'(6'b100000));
    rst = 1'b0;
    run_frame(8'h55, 2'd2, E55, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      in_ch    = 2'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (P + 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
